// File: rtl/freq_div_pkg.sv
// Shared defaults and state encoding for the clock-divider controller.
package freq_div_pkg;

    localparam int DIV_W_DEF   = 8;
    localparam int DEF_DIV_DEF = 5;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_e;

endpackage

// File: rtl/div_counter.sv
// Modulo-N phase counter: counts 0..div-1 while run is high, clr forces 0.
module div_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         run,
    input  logic [W-1:0] div,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_d, count_q;

    // div >= 2 is guaranteed by the controller, so div-1 never wraps
    assign tc    = run && (count_q == div - W'(1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (run)
            count_d = tc ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable 50%-duty clock divider with glitch-free divisor updates and
// a drain-to-low shutdown so div_out never produces a runt phase.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic             active
);

    state_e             state_d, state_q;
    logic [DIV_W-1:0]   div_d, div_q;
    logic [DIV_W-1:0]   pend_d, pend_q;
    logic               div_out_d, div_out_q;
    logic               tick_d, tick_q;
    logic               cfg_err_d, cfg_err_q;

    logic [DIV_W-1:0]   count;
    logic               tc;
    logic               running;
    logic               hs, hs_ok;
    logic               fall_now, at_zero;

    assign running   = (state_q != ST_OFF);
    assign cfg_ready = (state_q == ST_OFF) || (state_q == ST_RUN);
    assign active    = running;
    assign div_out   = div_out_q;
    assign tick      = tick_q;
    assign cfg_err   = cfg_err_q;

    assign hs       = cfg_valid && cfg_ready;
    assign hs_ok    = hs && (cfg_div >= DIV_W'(2));
    assign fall_now = tc && div_out_q;
    assign at_zero  = !div_out_q && (count == '0);

    div_counter #(.W(DIV_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!running),
        .run   (running),
        .div   (div_q),
        .count (count),
        .tc    (tc)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pend_d    = pend_q;
        cfg_err_d = hs && !hs_ok;
        // tick reports every toggle, including the final fall into OFF
        tick_d    = tc;
        div_out_d = div_out_q ^ tc;

        case (state_q)
            ST_OFF: begin
                if (hs_ok)
                    div_d = cfg_div;
                if (en)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en && (fall_now || at_zero)) begin
                    // already at (or landing on) the low boundary: stop now
                    state_d = ST_OFF;
                    if (hs_ok)
                        div_d = cfg_div;
                end else if (hs_ok) begin
                    pend_d  = cfg_div;
                    state_d = ST_PEND;
                end else if (!en) begin
                    state_d = ST_STOP;
                end
            end
            ST_PEND: begin
                if (fall_now) begin
                    div_d   = pend_q;
                    state_d = en ? ST_RUN : ST_OFF;
                end
            end
            ST_STOP: begin
                if (en)
                    state_d = ST_RUN;
                else if (fall_now)
                    state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            div_q     <= DIV_W'(DEF_DIV);
            pend_q    <= '0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed cycle-by-cycle bench: each step queues the outputs expected after
// the next edge, then pops and checks them once the edge has passed.
module tb_freq_div_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready, cfg_err, div_out, tick, active;

    typedef struct {
        logic  d, t, a, r, e;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;

    freq_div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .tick      (tick),
        .active    (active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d", ncmp);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input bit i_en, input bit i_cv, input logic [7:0] i_cd,
                       input logic e_d, input logic e_t, input logic e_a,
                       input logic e_r, input logic e_e, input string tag);
        exp_t x;
        en        = i_en;
        cfg_valid = i_cv;
        cfg_div   = i_cd;
        x.d = e_d; x.t = e_t; x.a = e_a; x.r = e_r; x.e = e_e; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        ncmp++;
        assert (div_out === x.d) else begin
            nerr++; $error("FAIL %s div_out got %b exp %b", x.tag, div_out, x.d);
        end
        ncmp++;
        assert (tick === x.t) else begin
            nerr++; $error("FAIL %s tick got %b exp %b", x.tag, tick, x.t);
        end
        ncmp++;
        assert (active === x.a) else begin
            nerr++; $error("FAIL %s active got %b exp %b", x.tag, active, x.a);
        end
        ncmp++;
        assert (cfg_ready === x.r) else begin
            nerr++; $error("FAIL %s cfg_ready got %b exp %b", x.tag, cfg_ready, x.r);
        end
        ncmp++;
        assert (cfg_err === x.e) else begin
            nerr++; $error("FAIL %s cfg_err got %b exp %b", x.tag, cfg_err, x.e);
        end
    endtask

    // n cycles of a running phase at level lvl; the toggle cycle carries tick
    task automatic phase(input int n, input logic lvl, input bit first_tick,
                         input string tag);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, 8'd0, lvl, first_tick && (i == 0), 1'b1, 1'b1, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;

        cyc(0, 0, 0, 0, 0, 0, 1, 0, "reset");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, "reset");
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 1, 0, "idle");

        // N=5: first rise N cycles after en, then 5 high / 5 low, tick per phase
        phase(5, 0, 0, "lead5");
        for (int p = 0; p < 7; p++)
            phase(5, (p % 2 == 0) ? 1'b1 : 1'b0, 1, "div5");

        // illegal divisor: handshake taken, one err pulse, period unchanged
        cyc(1, 0, 0, 0, 1, 1, 1, 0, "err");
        cyc(1, 1, 1, 0, 0, 1, 1, 1, "err_pulse");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, 0, 1, 1, 0, "err_clear");
        phase(5, 1, 1, "err_keep");
        phase(5, 0, 1, "err_keep");

        // update to 3 during high phase: PEND, high stays 5, then period 6
        cyc(1, 0, 0, 1, 1, 1, 1, 0, "pend");
        cyc(1, 1, 3, 1, 0, 1, 0, 0, "pend_enter");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 1, 0, 1, 0, 0, "pend_hold");
        phase(3, 0, 1, "n3");
        phase(3, 1, 1, "n3");
        phase(3, 0, 1, "n3");
        phase(3, 1, 1, "n3");

        // reset while an update to 7 is pending: back to N=5
        cyc(1, 0, 0, 0, 1, 1, 1, 0, "rstp");
        cyc(1, 1, 7, 0, 0, 1, 0, 0, "rstp_pend");
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 1, 0, "rstp_off");
        rst = 1'b0;
        phase(5, 0, 0, "after_rst");
        phase(5, 1, 1, "after_rst");
        phase(5, 0, 1, "after_rst");

        // en dropped 2 cycles into high phase: high still 5, then OFF
        cyc(1, 0, 0, 1, 1, 1, 1, 0, "stop");
        cyc(1, 0, 0, 1, 0, 1, 1, 0, "stop");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 1, 0, 1, 0, 0, "stop_drain");
        cyc(0, 0, 0, 0, 1, 0, 1, 0, "stop_off");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, "off_idle");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, "off_idle");

        // N=255 loaded in OFF together with en; en blip low/high mid-phase
        cyc(1, 1, 255, 0, 0, 1, 1, 0, "n255_load");
        phase(254, 0, 0, "n255_lead");
        cyc(1, 0, 0, 1, 1, 1, 1, 0, "n255_hi");
        cyc(1, 0, 0, 1, 0, 1, 1, 0, "n255_hi");
        cyc(1, 0, 0, 1, 0, 1, 1, 0, "n255_hi");
        cyc(0, 0, 0, 1, 0, 1, 0, 0, "n255_stop");
        cyc(1, 0, 0, 1, 0, 1, 1, 0, "n255_rerun");
        phase(250, 1, 0, "n255_hi");
        phase(255, 0, 1, "n255_lo");
        phase(2, 1, 1, "n255_hi2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
